turf_scanner: RTL and testbench

Read side of the 160×120 frame RAM that the game core writes player trails into. On a `start` pulse it sweeps every cell in raster order through the RAM read port and streams each cell to the VGA adapter as an (x, y, colour, plot) tuple. During the same sweep it tallies the cells owned by each of the four players. At end of frame it publishes per-player turf scores and the current leader.

---
 rtl/turf_pkg.sv | 31 +++
 rtl/turf_leader.sv | 37 +++
 rtl/turf_scanner.sv | 177 +++++++++++++++++
 tb/tb_turf_scanner.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/turf_pkg.sv
// Shared constants and address packing for the turf frame RAM.
// Used by both the scanner and the game-side trail writer.
package turf_pkg;

   localparam int X_CELLS = 160;
   localparam int Y_CELLS = 120;
   localparam int X_W     = 8;
   localparam int Y_W     = 7;
   localparam int ADDR_W  = X_W + Y_W;

   localparam logic [2:0] COL_EMPTY = 3'd0;
   localparam logic [2:0] COL_P1    = 3'd1;
   localparam logic [2:0] COL_P2    = 3'd2;
   localparam logic [2:0] COL_P3    = 3'd3;
   localparam logic [2:0] COL_P4    = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_READ,
      ST_DRAIN,
      ST_FINISH
   } state_t;

   function automatic logic [ADDR_W-1:0] pack_addr(
      input logic [X_W-1:0] x,
      input logic [Y_W-1:0] y
   );
      return {x, y};
   endfunction

endpackage

// File: rtl/turf_leader.sv
// Combinational 4-way maximum; ties resolve to the lowest player index.
// Reports 0 when no player owns any cell.
module turf_leader #(
   parameter int W = 15
) (
   input  logic [W-1:0] s1,
   input  logic [W-1:0] s2,
   input  logic [W-1:0] s3,
   input  logic [W-1:0] s4,
   output logic [2:0]   leader
);

   logic [W-1:0] best;

   // strict '>' keeps the earlier player on a tie
   always_comb begin
      best   = '0;
      leader = 3'd0;
      if (s1 > best) begin
         best   = s1;
         leader = 3'd1;
      end
      if (s2 > best) begin
         best   = s2;
         leader = 3'd2;
      end
      if (s3 > best) begin
         best   = s3;
         leader = 3'd3;
      end
      if (s4 > best) begin
         best   = s4;
         leader = 3'd4;
      end
   end

endmodule

// File: rtl/turf_scanner.sv
// Raster sweep of the frame RAM: streams every cell to the VGA adapter
// and publishes per-player turf scores plus the leader at end of frame.
module turf_scanner
   import turf_pkg::*;
#(
   parameter int X_CELLS = turf_pkg::X_CELLS,
   parameter int Y_CELLS = turf_pkg::Y_CELLS,
   parameter int SCORE_W = 15
) (
   input  logic               CLOCK_50,
   input  logic               reset,
   input  logic               start,
   output logic [ADDR_W-1:0]  ram_address,
   input  logic [2:0]         ram_q,
   output logic [X_W-1:0]     vga_x,
   output logic [Y_W-1:0]     vga_y,
   output logic [2:0]         vga_colour,
   output logic               vga_plot,
   output logic               busy,
   output logic               done,
   output logic [SCORE_W-1:0] score_p1,
   output logic [SCORE_W-1:0] score_p2,
   output logic [SCORE_W-1:0] score_p3,
   output logic [SCORE_W-1:0] score_p4,
   output logic [2:0]         leader
);

   localparam logic [X_W-1:0] X_LAST = X_W'(X_CELLS - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(Y_CELLS - 1);

   state_t state, state_nx;

   logic [X_W-1:0]     x, x_nx, x_d;
   logic [Y_W-1:0]     y, y_nx, y_d;
   logic               last_addr;
   logic               drain_cnt;
   logic               rd_v;
   logic               go, step, publish;
   logic [SCORE_W-1:0] acc1, acc2, acc3, acc4;
   logic [2:0]         lead_nx;

   assign last_addr = (x == X_LAST) && (y == Y_LAST);

   always_comb begin
      x_nx = x + X_W'(1);
      y_nx = y;
      if (x == X_LAST) begin
         x_nx = '0;
         y_nx = y + Y_W'(1);
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         ST_IDLE:   if (start) state_nx = ST_READ;
         ST_READ:   if (last_addr) state_nx = ST_DRAIN;
         ST_DRAIN:  if (drain_cnt) state_nx = ST_FINISH;
         ST_FINISH: state_nx = ST_IDLE;
         default:   state_nx = ST_IDLE;
      endcase
   end

   always_comb begin
      go      = 1'b0;
      step    = 1'b0;
      publish = 1'b0;
      unique case (state)
         ST_IDLE:  go      = start;
         ST_READ:  step    = ~last_addr;
         ST_DRAIN: publish = drain_cnt;
         default:  ;
      endcase
   end

   // address generation and control flags
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         x           <= '0;
         y           <= '0;
         ram_address <= '0;
         drain_cnt   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         busy      <= (state_nx != ST_IDLE);
         done      <= publish;
         drain_cnt <= (state == ST_DRAIN) ? ~drain_cnt : 1'b0;
         if (go) begin
            x           <= '0;
            y           <= '0;
            ram_address <= pack_addr('0, '0);
         end else if (step) begin
            x           <= x_nx;
            y           <= y_nx;
            ram_address <= pack_addr(x_nx, y_nx);
         end
      end
   end

   // x/y wait one cycle for ram_q, then the pixel is registered
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         rd_v       <= 1'b0;
         x_d        <= '0;
         y_d        <= '0;
         vga_x      <= '0;
         vga_y      <= '0;
         vga_colour <= '0;
         vga_plot   <= 1'b0;
      end else begin
         rd_v     <= (state == ST_READ);
         x_d      <= x;
         y_d      <= y;
         vga_plot <= rd_v;
         if (rd_v) begin
            vga_x      <= x_d;
            vga_y      <= y_d;
            vga_colour <= ram_q;
         end
      end
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         acc1 <= '0;
         acc2 <= '0;
         acc3 <= '0;
         acc4 <= '0;
      end else if (go) begin
         acc1 <= '0;
         acc2 <= '0;
         acc3 <= '0;
         acc4 <= '0;
      end else if (rd_v) begin
         unique case (ram_q)
            COL_P1:  acc1 <= acc1 + SCORE_W'(1);
            COL_P2:  acc2 <= acc2 + SCORE_W'(1);
            COL_P3:  acc3 <= acc3 + SCORE_W'(1);
            COL_P4:  acc4 <= acc4 + SCORE_W'(1);
            default: ;
         endcase
      end
   end

   turf_leader #(
      .W (SCORE_W)
   ) u_leader (
      .s1     (acc1),
      .s2     (acc2),
      .s3     (acc3),
      .s4     (acc4),
      .leader (lead_nx)
   );

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         score_p1 <= '0;
         score_p2 <= '0;
         score_p3 <= '0;
         score_p4 <= '0;
         leader   <= 3'd0;
      end else if (publish) begin
         score_p1 <= acc1;
         score_p2 <= acc2;
         score_p3 <= acc3;
         score_p4 <= acc4;
         leader   <= lead_nx;
      end
   end

endmodule

// File: tb/tb_turf_scanner.sv
// Bench for turf_scanner: RAM model, raster scoreboard and score model.
// Directed sweeps over constructed and randomised frame contents.
module tb_turf_scanner;

   localparam int XC = 160;
   localparam int YC = 120;
   localparam int NCELL = XC * YC;

   logic        CLOCK_50 = 1'b0;
   logic        reset;
   logic        start;
   logic [14:0] ram_address;
   logic [2:0]  ram_q;
   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic        busy;
   logic        done;
   logic [14:0] score_p1, score_p2, score_p3, score_p4;
   logic [2:0]  leader;

   logic [2:0] mem [0:XC-1][0:YC-1];

   int passed = 0;
   int total  = 0;
   int exp_s [1:4];
   int exp_lead;
   int new_s [1:4];
   int new_lead;

   always #10 CLOCK_50 = ~CLOCK_50;

   turf_scanner dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .start       (start),
      .ram_address (ram_address),
      .ram_q       (ram_q),
      .vga_x       (vga_x),
      .vga_y       (vga_y),
      .vga_colour  (vga_colour),
      .vga_plot    (vga_plot),
      .busy        (busy),
      .done        (done),
      .score_p1    (score_p1),
      .score_p2    (score_p2),
      .score_p3    (score_p3),
      .score_p4    (score_p4),
      .leader      (leader)
   );

   // synchronous-read RAM: data one cycle after the address
   always @(posedge CLOCK_50) begin
      int ax, ay;
      ax = int'(ram_address[14:7]);
      ay = int'(ram_address[6:0]);
      if (ax < XC && ay < YC) ram_q <= mem[ax][ay];
      else ram_q <= 3'd0;
   end

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < XC; i++)
         for (int j = 0; j < YC; j++)
            mem[i][j] = 3'd0;
   endtask

   // count each player's cells; leader is the first player holding the max
   task automatic model_scores();
      int mx;
      for (int p = 1; p <= 4; p++) new_s[p] = 0;
      for (int i = 0; i < XC; i++)
         for (int j = 0; j < YC; j++)
            if (mem[i][j] >= 3'd1 && mem[i][j] <= 3'd4)
               new_s[int'(mem[i][j])]++;
      mx = 0;
      for (int p = 1; p <= 4; p++) if (new_s[p] > mx) mx = new_s[p];
      new_lead = 0;
      for (int p = 4; p >= 1; p--)
         if (mx > 0 && new_s[p] == mx) new_lead = p;
   endtask

   function automatic bit scores_are(input int s [1:4], input int l);
      return score_p1 == 15'(s[1]) && score_p2 == 15'(s[2]) &&
             score_p3 == 15'(s[3]) && score_p4 == 15'(s[4]) &&
             leader == 3'(l);
   endfunction

   // called at a falling edge; that cycle is cycle 0 of the sweep
   task automatic sweep(input string nm, input int rst_cyc,
                        input int again_cyc);
      int plots, first_p, last_p, bad_pix, gaps, bad_busy;
      int bad_hold, dones, done_cyc;
      logic [7:0] ex;
      logic [6:0] ey;
      model_scores();
      plots = 0; first_p = -1; last_p = -1; bad_pix = 0; gaps = 0;
      bad_busy = 0; bad_hold = 0; dones = 0; done_cyc = -1;
      start = 1'b1;
      for (int cyc = 1; cyc <= NCELL + 4; cyc++) begin
         @(negedge CLOCK_50);
         if (cyc == 1 || cyc == again_cyc + 1) start = 1'b0;
         if (cyc == again_cyc) start = 1'b1;
         if (cyc == 1)
            check({nm, " addr_first"}, 32'(ram_address), 32'h0);
         if (cyc == NCELL)
            check({nm, " addr_last"}, 32'(ram_address),
                  32'({8'd159, 7'd119}));
         if (vga_plot === 1'b1) begin
            if (plots == 0) first_p = cyc;
            last_p = cyc;
            ex = 8'(plots % XC);
            ey = 7'(plots / XC);
            if (vga_x !== ex || vga_y !== ey ||
                vga_colour !== mem[int'(ex)][int'(ey)])
               bad_pix++;
            plots++;
         end
         if (vga_plot !== (cyc >= 3 && cyc <= NCELL + 2)) gaps++;
         if (busy !== (cyc <= NCELL + 3)) bad_busy++;
         if (done === 1'b1) begin
            dones++;
            done_cyc = cyc;
         end
         if (cyc < NCELL + 3 && !scores_are(exp_s, exp_lead)) bad_hold++;
         if (cyc == rst_cyc) begin
            reset = 1'b1;
            @(negedge CLOCK_50);
            check({nm, " rst_busy"}, 32'(busy), 32'd0);
            check({nm, " rst_plot"}, 32'(vga_plot), 32'd0);
            check({nm, " rst_done"}, 32'(dones + int'(done)), 32'd0);
            check({nm, " rst_score"},
                  32'(score_p1 | score_p2 | score_p3 | score_p4), 32'd0);
            check({nm, " rst_leader"}, 32'(leader), 32'd0);
            check({nm, " rst_addr"}, 32'(ram_address), 32'd0);
            check({nm, " rst_hold"}, 32'(bad_hold), 32'd0);
            for (int p = 1; p <= 4; p++) exp_s[p] = 0;
            exp_lead = 0;
            reset = 1'b0;
            return;
         end
      end
      check({nm, " plots"}, 32'(plots), 32'(NCELL));
      check({nm, " first_plot_cyc"}, 32'(first_p), 32'd3);
      check({nm, " last_plot_cyc"}, 32'(last_p), 32'(NCELL + 2));
      check({nm, " pixel_errs"}, 32'(bad_pix), 32'd0);
      check({nm, " plot_gaps"}, 32'(gaps), 32'd0);
      check({nm, " busy_errs"}, 32'(bad_busy), 32'd0);
      check({nm, " done_count"}, 32'(dones), 32'd1);
      check({nm, " done_cyc"}, 32'(done_cyc), 32'(NCELL + 3));
      check({nm, " score_hold_errs"}, 32'(bad_hold), 32'd0);
      check({nm, " score_p1"}, 32'(score_p1), 32'(new_s[1]));
      check({nm, " score_p2"}, 32'(score_p2), 32'(new_s[2]));
      check({nm, " score_p3"}, 32'(score_p3), 32'(new_s[3]));
      check({nm, " score_p4"}, 32'(score_p4), 32'(new_s[4]));
      check({nm, " leader"}, 32'(leader), 32'(new_lead));
      exp_s = new_s;
      exp_lead = new_lead;
   endtask

   initial begin
      int rx, ry;
      logic [2:0] cols [5];
      cols[0] = 3'd1; cols[1] = 3'd2; cols[2] = 3'd4;
      cols[3] = 3'd5; cols[4] = 3'd6;
      for (int p = 1; p <= 4; p++) exp_s[p] = 0;
      exp_lead = 0;
      start = 1'b0;
      reset = 1'b1;
      clear_mem();
      repeat (3) @(negedge CLOCK_50);
      check("reset addr", 32'(ram_address), 32'd0);
      check("reset vga", 32'({vga_x, vga_y, vga_colour, vga_plot}), 32'd0);
      check("reset busy_done", 32'({busy, done}), 32'd0);
      check("reset scores", 32'(score_p1 | score_p2 | score_p3 | score_p4),
            32'd0);
      check("reset leader", 32'(leader), 32'd0);
      reset = 1'b0;
      @(negedge CLOCK_50);

      // all-empty frame
      sweep("zero", -1, -1);

      // back-to-back sweep, corners only, stray start mid-sweep
      mem[0][0] = 3'd1;
      mem[159][119] = 3'd4;
      sweep("corner", -1, 500);

      // random frame, reset partway through
      for (int i = 0; i < XC; i++)
         for (int j = 0; j < YC; j++)
            mem[i][j] = 3'($urandom_range(0, 7));
      sweep("midreset", 8000, -1);

      // row 5 owned by player 3 plus random noise elsewhere
      clear_mem();
      for (int i = 0; i < XC; i++) mem[i][5] = 3'd3;
      for (int k = 0; k < 100; k++) begin
         rx = $urandom_range(0, XC - 1);
         ry = $urandom_range(0, YC - 2);
         if (ry >= 5) ry++;
         if (k < 40) mem[rx][ry] = 3'd7;
         else mem[rx][ry] = cols[$urandom_range(0, 4)];
      end
      sweep("row5", -1, -1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
